dac_mixer: RTL and testbench

Frame scheduler and mixer feeding the `dac_ctrl` stereo DAC controller in the fm-synth datapath. Once per audio frame, triggered by `dac_ctrl`'s `next` pulse, it polls up to NVOICE voice generators over a shared request/acknowledge bus. It sums their signed stereo samples with saturation and holds the result for presentation to `dac_ctrl` on the following `next`. It detects and flags frames in which the voices could not be collected in time (underrun).

---
 rtl/dac_mix_pkg.sv | 16 +
 rtl/dac_mix_sat.sv | 25 ++
 rtl/dac_mixer.sv | 129 ++++++++++++
 tb/tb_dac_mixer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dac_mix_pkg.sv
// Shared types and constants for the frame mixer: FSM encoding, sample width
// and the signed 16-bit saturation limits.
package dac_mix_pkg;

  localparam int unsigned SAMPLE_W = 16;

  localparam logic [SAMPLE_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [SAMPLE_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SAT  = 2'd2
  } mix_state_t;

endpackage : dac_mix_pkg

// File: rtl/dac_mix_sat.sv
// Combinational signed saturator: clamps an ACCW-bit accumulator into the
// signed 16-bit sample range.
module dac_mix_sat
  import dac_mix_pkg::*;
#(
  parameter int unsigned ACCW = 18
) (
  input  logic signed [ACCW-1:0]     acc,
  output logic        [SAMPLE_W-1:0] result_c
);

  localparam int unsigned HI_W = ACCW - SAMPLE_W + 1;

  logic [HI_W-1:0] hi;

  // The value fits when every bit from the sample sign bit upwards agrees.
  always_comb begin
    hi       = acc[ACCW-1:SAMPLE_W-1];
    result_c = acc[SAMPLE_W-1:0];
    if ((|hi) && !(&hi)) begin
      result_c = acc[ACCW-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule : dac_mix_sat

// File: rtl/dac_mixer.sv
// Per-frame voice scheduler and stereo mixer: polls enabled voices after each
// next pulse, accumulates, saturates, and presents the mix one frame later.
module dac_mixer
  import dac_mix_pkg::*;
#(
  parameter int unsigned NVOICE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                next,
  input  logic [NVOICE-1:0]   voice_en,
  output logic [NVOICE-1:0]   rd_req,
  input  logic [NVOICE-1:0]   rd_ack,
  input  logic [SAMPLE_W-1:0] voice_l,
  input  logic [SAMPLE_W-1:0] voice_r,
  output logic [SAMPLE_W-1:0] sample_l,
  output logic [SAMPLE_W-1:0] sample_r,
  output logic                underrun,
  input  logic                clr_underrun
);

  localparam int unsigned ACCW  = SAMPLE_W + $clog2(NVOICE);
  localparam int unsigned EXT_W = ACCW - SAMPLE_W;
  localparam int unsigned IDX_W = (NVOICE > 1) ? $clog2(NVOICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NVOICE - 1);

  mix_state_t               state, state_nxt;
  logic [IDX_W-1:0]         idx, idx_nxt;
  logic signed [ACCW-1:0]   acc_l, acc_l_nxt;
  logic signed [ACCW-1:0]   acc_r, acc_r_nxt;
  logic [SAMPLE_W-1:0]      pend_l, pend_l_nxt;
  logic [SAMPLE_W-1:0]      pend_r, pend_r_nxt;
  logic [SAMPLE_W-1:0]      sample_l_nxt, sample_r_nxt;
  logic                     underrun_nxt;
  logic [SAMPLE_W-1:0]      sat_l_c, sat_r_c;
  logic signed [ACCW-1:0]   ext_l, ext_r;

  assign ext_l = {{EXT_W{voice_l[SAMPLE_W-1]}}, voice_l};
  assign ext_r = {{EXT_W{voice_r[SAMPLE_W-1]}}, voice_r};

  dac_mix_sat #(.ACCW(ACCW)) u_sat_l (.acc(acc_l), .result_c(sat_l_c));
  dac_mix_sat #(.ACCW(ACCW)) u_sat_r (.acc(acc_r), .result_c(sat_r_c));

  // Request is decoded from registered state so it is stable within a cycle.
  always_comb begin
    rd_req = '0;
    if (state == REQ && voice_en[idx]) begin
      rd_req = NVOICE'(1) << idx;
    end
  end

  // Next-state logic; next overrides everything and restarts the frame.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    acc_l_nxt    = acc_l;
    acc_r_nxt    = acc_r;
    pend_l_nxt   = pend_l;
    pend_r_nxt   = pend_r;
    sample_l_nxt = sample_l;
    sample_r_nxt = sample_r;
    underrun_nxt = underrun;

    if (clr_underrun) begin
      underrun_nxt = 1'b0;
    end

    if (next) begin
      sample_l_nxt = pend_l;
      sample_r_nxt = pend_r;
      acc_l_nxt    = '0;
      acc_r_nxt    = '0;
      idx_nxt      = '0;
      state_nxt    = REQ;
      if (state != IDLE) begin
        underrun_nxt = 1'b1;
      end
    end else begin
      case (state)
        REQ: begin
          if (!voice_en[idx] || rd_ack[idx]) begin
            if (voice_en[idx]) begin
              acc_l_nxt = acc_l + ext_l;
              acc_r_nxt = acc_r + ext_r;
            end
            if (idx == IDX_LAST) begin
              state_nxt = SAT;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end
        end
        SAT: begin
          pend_l_nxt = sat_l_c;
          pend_r_nxt = sat_r_c;
          state_nxt  = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      acc_l    <= '0;
      acc_r    <= '0;
      pend_l   <= '0;
      pend_r   <= '0;
      sample_l <= '0;
      sample_r <= '0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      acc_l    <= acc_l_nxt;
      acc_r    <= acc_r_nxt;
      pend_l   <= pend_l_nxt;
      pend_r   <= pend_r_nxt;
      sample_l <= sample_l_nxt;
      sample_r <= sample_r_nxt;
      underrun <= underrun_nxt;
    end
  end

endmodule : dac_mixer

// File: tb/tb_dac_mixer.sv
// Directed bench for dac_mixer with four behavioural voices that answer
// requests combinationally unless masked off.
module tb_dac_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic        next;
  logic [3:0]  voice_en;
  logic [3:0]  rd_req;
  logic [3:0]  rd_ack;
  logic [15:0] voice_l;
  logic [15:0] voice_r;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        underrun;
  logic        clr_underrun;

  logic [3:0]  ack_mask;
  logic [15:0] vl [4];
  logic [15:0] vr [4];

  int tests = 0;
  int fails = 0;

  dac_mixer #(.NVOICE(4)) dut (
    .clk(clk), .reset(reset), .next(next), .voice_en(voice_en),
    .rd_req(rd_req), .rd_ack(rd_ack), .voice_l(voice_l), .voice_r(voice_r),
    .sample_l(sample_l), .sample_r(sample_r), .underrun(underrun),
    .clr_underrun(clr_underrun)
  );

  always #10 clk = ~clk;

  // Voices drive the shared bus only while selected.
  always_comb begin
    rd_ack  = rd_req & ack_mask;
    voice_l = '0;
    voice_r = '0;
    for (int i = 0; i < 4; i++) begin
      if (rd_req[i]) begin
        voice_l = vl[i];
        voice_r = vr[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_next();
    next = 1'b1;
    tick();
    next = 1'b0;
  endtask

  task automatic set_voices(input logic [15:0] l, input logic [15:0] r);
    for (int i = 0; i < 4; i++) begin
      vl[i] = l;
      vr[i] = r;
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests++; if (sample_l !== 16'h0) begin fails++; $display("FAIL reset_sample_l got %h exp 0000", sample_l); end
    tests++; if (sample_r !== 16'h0) begin fails++; $display("FAIL reset_sample_r got %h exp 0000", sample_r); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun got %b exp 0", underrun); end
    tests++; if (rd_req !== 4'b0000) begin fails++; $display("FAIL reset_rd_req got %b exp 0000", rd_req); end
  endtask

  task automatic test_basic_mix();
    voice_en = 4'b1111;
    ack_mask = 4'b1111;
    set_voices(16'h1000, 16'hFFFF);
    pulse_next();
    tests++; if (rd_req !== 4'b0001) begin fails++; $display("FAIL basic_first_req got %b exp 0001", rd_req); end
    settle();
    pulse_next();
    tests++; if (sample_l !== 16'h4000) begin fails++; $display("FAIL basic_l got %h exp 4000", sample_l); end
    tests++; if (sample_r !== 16'hFFFC) begin fails++; $display("FAIL basic_r got %h exp fffc", sample_r); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL basic_underrun got %b exp 0", underrun); end
  endtask

  task automatic test_saturate();
    settle();
    set_voices(16'h7000, 16'h9000);
    pulse_next();
    settle();
    pulse_next();
    tests++; if (sample_l !== 16'h7FFF) begin fails++; $display("FAIL sat_l got %h exp 7fff", sample_l); end
    tests++; if (sample_r !== 16'h8000) begin fails++; $display("FAIL sat_r got %h exp 8000", sample_r); end
  endtask

  task automatic test_sparse();
    logic [3:0] exp_req [5];
    exp_req = '{4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    settle();
    voice_en = 4'b0101;
    vl = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    vr = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
    pulse_next();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (rd_req !== exp_req[i]) begin
        fails++; $display("FAIL sparse_req[%0d] got %b exp %b", i, rd_req, exp_req[i]);
      end
      tick();
    end
    // Fifth edge after next has loaded pend, so this next is on time.
    pulse_next();
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL sparse_underrun got %b exp 0", underrun); end
    tests++; if (sample_l !== 16'h0400) begin fails++; $display("FAIL sparse_l got %h exp 0400", sample_l); end
    tests++; if (sample_r !== 16'h0040) begin fails++; $display("FAIL sparse_r got %h exp 0040", sample_r); end
  endtask

  task automatic test_underrun();
    settle();
    voice_en = 4'b1111;
    ack_mask = 4'b0111;
    set_voices(16'h0111, 16'h0222);
    pulse_next();
    settle();
    tests++; if (rd_req !== 4'b1000) begin fails++; $display("FAIL stall_req got %b exp 1000", rd_req); end
    pulse_next();
    tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL underrun_set got %b exp 1", underrun); end
    tests++; if (sample_l !== 16'h0400) begin fails++; $display("FAIL underrun_repeat_l got %h exp 0400", sample_l); end
    tests++; if (sample_r !== 16'h0040) begin fails++; $display("FAIL underrun_repeat_r got %h exp 0040", sample_r); end
    tests++; if (rd_req !== 4'b0001) begin fails++; $display("FAIL underrun_restart_req got %b exp 0001", rd_req); end
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL underrun_clear got %b exp 0", underrun); end
    ack_mask = 4'b1111;
  endtask

  task automatic test_reset_mid_frame();
    settle();
    ack_mask = 4'b1101;
    pulse_next();
    pulse_next();
    for (int i = 0; i < 10 && rd_req !== 4'b0010; i++) tick();
    tests++; if (rd_req !== 4'b0010) begin fails++; $display("FAIL midreset_pre_req got %b exp 0010", rd_req); end
    tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL midreset_pre_underrun got %b exp 1", underrun); end
    reset = 1'b1;
    next  = 1'b1;
    tick();
    reset = 1'b0;
    next  = 1'b0;
    tests++; if (rd_req !== 4'b0000) begin fails++; $display("FAIL midreset_req got %b exp 0000", rd_req); end
    tests++; if (sample_l !== 16'h0) begin fails++; $display("FAIL midreset_l got %h exp 0000", sample_l); end
    tests++; if (sample_r !== 16'h0) begin fails++; $display("FAIL midreset_r got %h exp 0000", sample_r); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL midreset_underrun got %b exp 0", underrun); end
    ack_mask = 4'b1111;
    tick();
    tick();
    tests++; if (rd_req !== 4'b0000) begin fails++; $display("FAIL midreset_idle_req got %b exp 0000", rd_req); end
  endtask

  task automatic test_clr_collision();
    voice_en = 4'b1111;
    pulse_next();
    next         = 1'b1;
    clr_underrun = 1'b1;
    tick();
    next         = 1'b0;
    clr_underrun = 1'b0;
    tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL clr_collision got %b exp 1", underrun); end
  endtask

  initial begin
    reset        = 1'b1;
    next         = 1'b0;
    voice_en     = 4'b0000;
    clr_underrun = 1'b0;
    ack_mask     = 4'b1111;
    set_voices(16'h0000, 16'h0000);
    test_reset();
    test_basic_mix();
    test_saturate();
    test_sparse();
    test_underrun();
    test_reset_mid_frame();
    test_clr_collision();
    settle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_dac_mixer
